// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 key-matrix scanner with whole-scan debounce and bus
// registers at 0xf4 KEY, 0xf5 DEBLO, 0xf6 DEBHI, 0xf7 CTRL.
// Build option KEYPAD_IRQ_EN: irq = valid & irq_mask with the mask in CTRL
// bit2; when undefined irq is tied low and CTRL bit2 reads 0.
//
// state   | meaning
// IDLE    | scanning stopped, all rows released
// SCAN    | row `row` driven low for 2^SCAN_BITS cycles, sampled on last cycle
// COMPARE | one cycle: debounce the full scan, commit, raise key events
module keypad_scan #(
  parameter int SCAN_BITS = 12,
  parameter int DEB_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] addr,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic       irq
);
  localparam logic [3:0] DEB_MAX = 4'(DEB_SCANS);

  typedef enum logic [1:0] {IDLE, SCAN, COMPARE} state_t;

  state_t               state;
  logic [1:0]           row;
  logic [SCAN_BITS-1:0] tmr;
  logic [15:0]          scan_buf;
  logic [15:0]          prev_buf;
  logic [15:0]          deb;
  logic [3:0]           stable;
  logic                 valid;
  logic                 overrun;
  logic [3:0]           code;
  logic                 enable;
  logic [3:0]           col_meta;
  logic [3:0]           col_sync;

  logic wr_ctrl, rd_key, clr, en_next;
  assign wr_ctrl = we && (addr == 8'hf7);
  assign rd_key  = re && (addr == 8'hf4);
  assign clr     = wr_ctrl && in[1];
  // a CTRL write takes effect on the FSM in the same cycle it is issued
  assign en_next = wr_ctrl ? in[0] : enable;

  logic [15:0] new_keys;
  logic [3:0]  stable_next;
  logic [3:0]  new_code;
  logic        commit, event_hit, multi, valid_eff, overrun_eff;

  // debounce decision and press-event encoding for the COMPARE cycle
  always_comb begin
    stable_next = (scan_buf == prev_buf) ?
                  ((stable >= DEB_MAX) ? DEB_MAX : stable + 4'd1) : 4'd1;
    commit      = (state == COMPARE) && (stable_next == DEB_MAX) && (scan_buf != deb);
    new_keys    = scan_buf & ~deb;
    event_hit   = commit && (new_keys != 16'h0);
    multi       = (new_keys & (new_keys - 16'd1)) != 16'h0;
    new_code    = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (new_keys[k]) new_code = 4'(k);
    end
    // a clearing read in the same cycle as an event acts as if it came first
    valid_eff   = valid && !rd_key;
    overrun_eff = overrun && !rd_key;
  end

  // two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // scan FSM, debounce state and the KEY/CTRL registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= 2'd0;
      tmr      <= '0;
      row_n    <= 4'b1111;
      scan_buf <= 16'h0;
      prev_buf <= 16'h0;
      deb      <= 16'h0;
      stable   <= 4'd0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      code     <= 4'd0;
      enable   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (en_next) begin
            state <= SCAN;
            row   <= 2'd0;
            tmr   <= '1;
            row_n <= 4'b1110;
          end
        end
        SCAN: begin
          if (!en_next) begin
            state    <= IDLE;
            row_n    <= 4'b1111;
            scan_buf <= 16'h0;
            stable   <= 4'd0;
          end else begin
            tmr <= tmr - SCAN_BITS'(1);
            if (tmr == '0) begin
              scan_buf[{row, 2'b00} +: 4] <= ~col_sync;
              if (row == 2'd3) begin
                state <= COMPARE;
                row_n <= 4'b1111;
              end else begin
                row   <= row + 2'd1;
                tmr   <= '1;
                row_n <= ~(4'b0001 << (row + 2'd1));
              end
            end
          end
        end
        COMPARE: begin
          prev_buf <= scan_buf;
          stable   <= stable_next;
          if (commit) deb <= scan_buf;
          if (en_next) begin
            state <= SCAN;
            row   <= 2'd0;
            tmr   <= '1;
            row_n <= 4'b1110;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          row_n <= 4'b1111;
        end
      endcase

      if (event_hit) begin
        valid   <= 1'b1;
        code    <= new_code;
        overrun <= overrun_eff | valid_eff | multi;
      end else if (rd_key) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      if (wr_ctrl) enable <= in[0];

      // clear beats a commit landing in the same cycle
      if (clr) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
        code    <= 4'd0;
        deb     <= 16'h0;
        stable  <= 4'd0;
      end
    end
  end

`ifdef KEYPAD_IRQ_EN
  logic irq_mask;
  logic unused_in;
  assign unused_in = ^in[7:3];

  // interrupt mask held in CTRL bit2
  always_ff @(posedge clk) begin
    if (!rst_n)       irq_mask <= 1'b0;
    else if (wr_ctrl) irq_mask <= in[2];
  end
`else
  logic irq_mask;
  logic unused_in;
  assign irq_mask  = 1'b0;
  assign unused_in = ^in[7:2];
`endif

  assign irq = valid & irq_mask;

  // registered read mux, loaded every cycle from addr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= 8'h00;
    end else begin
      case (addr)
        8'hf4:   out <= {valid, overrun, 2'b00, code};
        8'hf5:   out <= deb[7:0];
        8'hf6:   out <= deb[15:8];
        8'hf7:   out <= {5'b00000, irq_mask, 1'b0, enable};
        default: out <= 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan (SCAN_BITS=2, DEB_SCANS=2): register table,
// hand-written debounce/overrun/clear/disable/irq sequences, then random
// key patterns checked against a scan-level reference model.
module tb_keypad_scan;
  localparam int DEB = 2;
`ifdef KEYPAD_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, we, re, irq;
  logic [7:0] addr, din, out;
  logic [3:0] row_n, col_n;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;

  keypad_scan #(.SCAN_BITS(2), .DEB_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .in(din),
    .out(out), .row_n(row_n), .col_n(col_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // key matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~keys[4*r +: 4];
    end
  end

  // scan-level reference model
  int          m_stable;
  logic [15:0] m_prev, m_deb;
  logic        m_valid, m_ovr, m_en, m_mask;
  logic [3:0]  m_code;

  task automatic m_reset();
    m_stable = 0; m_prev = 16'h0; m_deb = 16'h0;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'd0; m_en = 1'b1; m_mask = 1'b0;
  endtask

  task automatic m_clear();
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'd0; m_deb = 16'h0; m_stable = 0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    logic [15:0] nw;
    int lo;
    m_stable = (k == m_prev) ? ((m_stable < DEB) ? m_stable + 1 : DEB) : 1;
    m_prev = k;
    if (m_stable == DEB && k != m_deb) begin
      nw = k & ~m_deb;
      m_deb = k;
      if (nw != 16'h0) begin
        lo = 0;
        while (!nw[lo]) lo++;
        m_ovr   = m_ovr | m_valid | ($countones(nw) > 1);
        m_valid = 1'b1;
        m_code  = 4'(lo);
      end
    end
  endtask

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    case (a)
      8'hf4:   return {m_valid, m_ovr, 2'b00, m_code};
      8'hf5:   return m_deb[7:0];
      8'hf6:   return m_deb[15:8];
      8'hf7:   return {5'b00000, m_mask, 1'b0, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_row(input logic [3:0] v, input string nm);
    int n = 0;
    while (row_n !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    check8(nm, {4'b0, row_n}, {4'b0, v});
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0; addr = 8'h00;
    check8(nm, out, exp);
    if (a == 8'hf4) begin m_valid = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    @(negedge clk);
    we = 1'b0; addr = 8'h00; din = 8'h00;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    wr(8'hf7, d);
    m_en = d[0];
    m_mask = IRQ_EN & d[2];
    if (d[1]) m_clear();
  endtask

  // finish the scan in progress (modelled with the keys it saw), then
  // present k for the following scan; returns one cycle into that scan
  task automatic step(input logic [15:0] k);
    wait_row(4'b1111, "scan_end");
    model_scan(keys);
    keys = k;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;
  vec_t vecs [0:10];

  task automatic run_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].w) wr(vecs[i].a, vecs[i].d);
      else rd(vecs[i].a, vecs[i].e, $sformatf("%s_vec%0d", tag, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] k;
    logic        held;

    vecs[0]  = '{1'b1, 8'hf4, 8'hff, 8'h00};
    vecs[1]  = '{1'b1, 8'hf5, 8'hff, 8'h00};
    vecs[2]  = '{1'b1, 8'hf6, 8'hff, 8'h00};
    vecs[3]  = '{1'b0, 8'hf4, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 8'hf5, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 8'hf6, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 8'hf7, 8'h00, 8'h01};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 8'hf3, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 8'hf8, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 8'hff, 8'h00, 8'h00};

    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 8'h00; din = 8'h00; keys = 16'h0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check8("rst_row_n", {4'b0, row_n}, 8'h0f);
    check8("rst_out", out, 8'h00);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    wait_row(4'b1110, "rst_scan_start");
    run_table("rst");

    // single press of key 9 held
    step(16'h0200);
    step(16'h0200);
    step(16'h0200);
    rd(8'hf4, 8'h89, "press_key");
    rd(8'hf5, 8'h00, "press_deblo");
    rd(8'hf6, 8'h02, "press_debhi");
    rd(8'hf4, 8'h09, "press_key_reread");

    // bounce: key 9 toggling every scan never commits
    wr_ctrl(8'h03);
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 16'h0000 : 16'h0200);
    rd(8'hf4, 8'h00, "bounce_key");
    rd(8'hf5, 8'h00, "bounce_deblo");
    rd(8'hf6, 8'h00, "bounce_debhi");
    step(16'h0200);
    step(16'h0200);
    rd(8'hf4, 8'h89, "bounce_settled");

    // overrun: key 0 committed unread, then key 15 added
    wr_ctrl(8'h03);
    step(16'h0001);
    step(16'h0001);
    step(16'h8001);
    step(16'h8001);
    step(16'h8001);
    rd(8'hf4, 8'hcf, "overrun_key");
    rd(8'hf4, 8'h0f, "overrun_reread");

    // clearing read in the commit cycle: event wins, overrun as if valid was 0
    step(16'h8009);
    step(16'h8009);
    step(16'h8089);
    step(16'h8089);
    wait_row(4'b1111, "sim_read_cmp");
    rd(8'hf4, 8'h83, "sim_read_pre");
    model_scan(keys);
    rd(8'hf4, 8'h87, "sim_read_post");

    // CTRL clear in the commit cycle: clear wins
    step(16'h0002);
    step(16'h0002);
    wait_row(4'b1111, "sim_clear_cmp");
    model_scan(keys);
    wr_ctrl(8'h03);
    rd(8'hf4, 8'h00, "sim_clear_key");
    rd(8'hf5, 8'h00, "sim_clear_deblo");
    rd(8'hf6, 8'h00, "sim_clear_debhi");

    // disable mid-scan, deb held, re-enable restarts at row 0
    step(16'h0002);
    step(16'h0002);
    wait_row(4'b1101, "dis_row1");
    wr_ctrl(8'h00);
    m_stable = 0;
    check8("dis_row_n", {4'b0, row_n}, 8'h0f);
    held = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (row_n !== 4'b1111) held = 1'b0;
    end
    check8("dis_held", {7'b0, held}, 8'h01);
    rd(8'hf5, 8'h02, "dis_deblo");
    rd(8'hf6, 8'h00, "dis_debhi");
    rd(8'hf4, 8'h81, "dis_key");
    rd(8'hf7, 8'h00, "dis_ctrl");
    wr_ctrl(8'h01);
    check8("reen_row_n", {4'b0, row_n}, 8'h0e);

    // irq with mask set, cleared by a KEY read
    wr_ctrl(8'h07);
    rd(8'hf7, IRQ_EN ? 8'h05 : 8'h01, "irq_ctrl");
    step(16'h0008);
    step(16'h0008);
    step(16'h0008);
    check8("irq_set", {7'b0, irq}, {7'b0, IRQ_EN});
    rd(8'hf4, 8'h83, "irq_key");
    check8("irq_clr", {7'b0, irq}, 8'h00);

    // random key patterns against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) k = keys;
      else k = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(k);
      check8($sformatf("rnd%0d_irq", it), {7'b0, irq}, {7'b0, m_valid & m_mask});
      if ($urandom_range(0, 1) == 1) rd(8'hf4, m_reg(8'hf4), $sformatf("rnd%0d_key", it));
      rd(8'hf5, m_reg(8'hf5), $sformatf("rnd%0d_deblo", it));
      rd(8'hf6, m_reg(8'hf6), $sformatf("rnd%0d_debhi", it));
    end

    // reset in the middle of a scan with keys held
    keys = 16'h1234;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check8("midrst_row_n", {4'b0, row_n}, 8'h0f);
    check8("midrst_out", out, 8'h00);
    check8("midrst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    m_reset();
    wait_row(4'b1110, "midrst_scan_start");
    run_table("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Memory-mapped 4x4 key-matrix input peripheral. It is the input-side counterpart of the multiplexed LED/digit output driver.
- Drives one matrix row low at a time and samples the active-low column lines. Debounces over whole scans and latches press events into CPU-readable registers at 0xf4-0xf7.
- Shares the CPU I/O bus (addr/we/in) with the other peripherals and adds re/out for the read path.

Parameters:
- SCAN_BITS, 12: each row slot lasts 2^SCAN_BITS cycles. Legal minimum is 2.
- DEB_SCANS, 3: number of consecutive identical full scans required to commit a new key state. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- we  input  1  bus write strobe
- re  input  1  bus read strobe
- addr  input  8  bus address
- in  input  8  bus write data
- out  output  8  bus read data, registered
- row_n  output  4  matrix row drive, active-low, one-hot-low
- col_n  input  4  matrix column sense, active-low, asynchronous
- irq  output  1  key-event interrupt, level

Behaviour:
- Reset: rst_n sampled on posedge clk, active-low, synchronous. Reset values:
  - row_n=4'b1111, out=8'h00, irq=0
  - valid=0, overrun=0, code=0
  - debounced state deb[15:0]=0, stable count=0
  - enable=1, FSM=IDLE, column synchronizer=4'b1111
- Column input: col_n passes through a 2-FF synchronizer before any use.
- Registers (out is loaded every cycle from the addr mux; 1-cycle read latency):
  - 0xf4 KEY: {valid, overrun, 2'b00, code[3:0]}
  - 0xf5 DEBLO: deb[7:0]
  - 0xf6 DEBHI: deb[15:8]
  - 0xf7 CTRL: {7'b0, enable}. Write: bit0 = enable; bit1 = clear (self-clearing pulse; zeroes valid, overrun, code, deb and stable count).
  - Any other address returns 8'h00.
  - Writes to 0xf4-0xf6 are ignored.
- Read side effect: re=1 with addr=0xf4 clears valid and overrun at the end of that cycle. out still shows the pre-clear value.
- Key index = row*4 + col. deb bit k = 1 means key k is pressed.
- FSM:
  - IDLE: row_n=1111. Go to SCAN row 0 when enable=1.
  - SCAN(r): row_n[r]=0, others 1, held for 2^SCAN_BITS cycles.
    - On the last cycle of the slot, capture ~col_sync into scan_buf[4r+3:4r].
    - r<3: go to SCAN(r+1). r=3: go to COMPARE.
  - COMPARE: 1 cycle, row_n=1111.
    - If scan_buf==prev_buf: stable count increments, saturating at DEB_SCANS. Otherwise stable count=1.
    - prev_buf<=scan_buf.
    - If stable count reaches DEB_SCANS (including the cycle it reaches it) and scan_buf!=deb: commit deb<=scan_buf.
    - Then go to SCAN(0), or IDLE if enable=0.
  - Full scan period = 4*2^SCAN_BITS + 1 cycles.
- Event on commit:
  - new = scan_buf & ~deb_old. Releases produce no event.
  - If new is nonzero: code = index of the lowest set bit of new, and valid=1.
  - overrun=1 if valid was already 1 or new has more than one bit set.
- Simultaneous clearing read of 0xf4 and a commit event in the same cycle: the event wins (valid=1; overrun computed as if valid had been 0).
- Simultaneous CTRL clear and commit in the same cycle: clear wins.
- enable written 0 mid-scan: next cycle goes to IDLE with row_n=1111. The partial scan_buf is discarded and stable count=0. deb, valid and code are held.
- Re-enable: the scan restarts at row 0.
- Reset mid-scan returns every register to its reset value next cycle.

Optional Feature:
- Macro KEYPAD_IRQ_EN.
  - Defined: irq = valid & irq_mask, where irq_mask is CTRL bit2 (reset 0, readable in 0xf7 bit2).
  - Undefined: irq tied to 0, CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles -> row_n=1111, out=00, irq=0; with re and addr=0xf4/f5/f6/f7 reads give 00,00,00,01.
- Single press, SCAN_BITS=2, DEB_SCANS=2: col_n[1]=0 only while row_n[2]=0, held for the whole test -> within 3 scans (51 cycles) 0xf4 reads 8'h89 and 0xf5/f6 read 00/02. A second 0xf4 read returns 8'h09.
- Bounce: toggle key 9 on alternate scans for 6 scans -> valid stays 0 and deb stays 0. Then hold for 2 scans -> valid=1, code=9.
- Overrun: press key 0 and commit without reading, then add key 15 -> 0xf4 reads 8'hCF, and the following read returns 8'h0F.
- Disable: write 0xf7=00 during row 1 -> next cycle row_n=1111 held indefinitely and deb unchanged. Write 01 -> scanning restarts with row_n=1110.
- IRQ (with KEYPAD_IRQ_EN): write 0xf7=05, press key 3 -> irq=1 after commit. Read 0xf4 -> irq=0 the next cycle.
